// File: rtl/ahb_timeout_recorder.sv
`default_nettype none
// ============================================================================
// Module      : ahb_timeout_recorder
// Description : Passive companion to the AHB-Lite timeout monitor. It snoops
//               the slave-side address phase and, on each rising edge of the
//               monitor's TIMEOUT status, records the transfer attributes,
//               counts the event (saturating) and raises a level interrupt.
//               The recorded state is read through a 4-word APB bank that
//               runs on HCLK.
// Ports       : HCLK, HRESETn           - clock, async active-low reset
//               HSELS/HADDRS/HTRANSS/
//               HWRITES/HSIZES/HREADYS  - snooped slave-side AHB-Lite bus
//               TIMEOUT                 - monitor timeout state
//               PSEL/PENABLE/PWRITE/
//               PADDR/PWDATA            - APB request (PADDR = byte addr [3:2])
//               PRDATA/PREADY/PSLVERR   - APB response
//               IRQ                     - registered interrupt (level)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_timeout_recorder #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic                  HREADYS,
  input  logic                  TIMEOUT,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [1:0]            PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  IRQ
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Address-phase attributes of the most recent accepted transfer
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  pend_write;
  logic [2:0]            pend_size;

  logic                  tout_d;
  logic                  irqen;
  logic                  valid;
  logic                  ovf;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [2:0]            cap_size;
  logic [CNT_WIDTH-1:0]  count;

  logic                  snoop;
  logic                  tout_rise;
  logic                  apb_wr;
  logic                  status_clr;
  logic                  count_clr;
  logic                  valid_kept;
  logic [CNT_WIDTH-1:0]  count_base;
  logic [31:0]           rd_mux;

  assign snoop      = HREADYS & HSELS & HTRANSS[1];
  assign tout_rise  = TIMEOUT & ~tout_d;
  assign apb_wr     = PSEL & PENABLE & PWRITE;
  assign status_clr = apb_wr & (PADDR == 2'd1) & PWDATA[0];
  assign count_clr  = apb_wr & (PADDR == 2'd3);

  // A STATUS clear in the same cycle as an event is applied first, so the
  // event then sees an empty record and captures instead of overflowing.
  assign valid_kept = valid & ~status_clr;
  // Likewise an INFO write zeroes the counter before the event is added.
  assign count_base = count_clr ? '0 : count;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_addr  <= '0;
      pend_write <= 1'b0;
      pend_size  <= 3'd0;
    end else if (snoop) begin
      pend_addr  <= HADDRS;
      pend_write <= HWRITES;
      pend_size  <= HSIZES;
    end
  end

  // tout_d resets to 0, so TIMEOUT already high at reset release is an event
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tout_d <= 1'b0;
    end else begin
      tout_d <= TIMEOUT;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irqen <= 1'b0;
    end else if (apb_wr && (PADDR == 2'd0)) begin
      irqen <= PWDATA[0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid     <= 1'b0;
      ovf       <= 1'b0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_size  <= 3'd0;
    end else if (tout_rise) begin
      valid <= 1'b1;
      if (valid_kept) begin
        ovf <= 1'b1;
      end else begin
        ovf       <= 1'b0;
        cap_addr  <= pend_addr;
        cap_write <= pend_write;
        cap_size  <= pend_size;
      end
    end else if (status_clr) begin
      valid <= 1'b0;
      ovf   <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count <= '0;
    end else if (count_clr || tout_rise) begin
      if (tout_rise && (count_base != CNT_MAX)) begin
        count <= count_base + CNT_ONE;
      end else begin
        count <= count_base;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= irqen & valid;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (PADDR)
      2'd0: rd_mux[0] = irqen;
      2'd1: rd_mux[2:0] = {TIMEOUT, ovf, valid};
      2'd2: rd_mux[ADDR_WIDTH-1:0] = cap_addr;
      2'd3: begin
        rd_mux[16 +: CNT_WIDTH] = count;
        rd_mux[4]               = cap_write;
        rd_mux[2:0]             = cap_size;
      end
    endcase
  end

  assign PRDATA  = (PSEL && !PWRITE) ? rd_mux : 32'd0;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  // Only bit 0 of write data and HTRANS[1] carry meaning here
  logic unused_inputs;
  assign unused_inputs = &{1'b0, PWDATA[31:1], HTRANSS[0]};

endmodule
`default_nettype wire

// File: tb/tb_ahb_timeout_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_timeout_recorder
// Description : Bench for ahb_timeout_recorder. Two instances share stimulus:
//               a default one (32-bit address, 8-bit counter) and a narrow one
//               (16-bit address, 2-bit counter). A behavioural model tracks
//               the recorder as events and register writes, and the outputs
//               of both instances are compared with it every cycle. Directed
//               scenarios add literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_timeout_recorder;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS, HWRITES, HREADYS, TIMEOUT;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES;
  logic        PSEL, PENABLE, PWRITE;
  logic [1:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA, prdata2;
  logic        PREADY, PSLVERR, IRQ, pready2, pslverr2, irq2;

  always #5 HCLK = ~HCLK;

  ahb_timeout_recorder #(.ADDR_WIDTH(32), .CNT_WIDTH(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HREADYS(HREADYS),
    .TIMEOUT(TIMEOUT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .IRQ(IRQ)
  );

  ahb_timeout_recorder #(.ADDR_WIDTH(16), .CNT_WIDTH(2)) dut_n (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS[15:0]),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HREADYS(HREADYS),
    .TIMEOUT(TIMEOUT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata2), .PREADY(pready2),
    .PSLVERR(pslverr2), .IRQ(irq2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // The record is described as "last accepted transfer", "recorded
  // transfer", and a plain integer count of events since the last clear;
  // each instance's counter width only limits what that count reads as.
  logic [31:0] m_paddr, m_caddr;
  logic        m_pwrite, m_cwrite;
  logic [2:0]  m_psize, m_csize;
  logic        m_tprev, m_irqen, m_valid, m_ovf, m_irq;
  int          m_cnt;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_paddr = 0; m_pwrite = 0; m_psize = 0; m_tprev = 0;
      m_caddr = 0; m_cwrite = 0; m_csize = 0;
      m_irqen = 0; m_valid = 0; m_ovf = 0; m_irq = 0; m_cnt = 0;
    end else begin
      bit ev, wr;
      ev = TIMEOUT && !m_tprev;
      wr = PSEL && PENABLE && PWRITE;
      m_irq = m_irqen && m_valid;
      if (wr && PADDR == 2'd0) m_irqen = PWDATA[0];
      if (wr && PADDR == 2'd1 && PWDATA[0]) begin m_valid = 0; m_ovf = 0; end
      if (wr && PADDR == 2'd3) m_cnt = 0;
      if (ev) begin
        if (m_valid) m_ovf = 1;
        else begin
          m_valid = 1; m_caddr = m_paddr; m_cwrite = m_pwrite; m_csize = m_psize;
        end
        m_cnt++;
      end
      if (HREADYS && HSELS && HTRANSS[1]) begin
        m_paddr = HADDRS; m_pwrite = HWRITES; m_psize = HSIZES;
      end
      m_tprev = TIMEOUT;
    end
  end

  function automatic logic [31:0] exp_rd(input int aw, input int cw);
    logic [31:0] r, mask;
    int mx, c;
    r = 0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        2'd0: r[0] = m_irqen;
        2'd1: r[2:0] = {TIMEOUT, m_ovf, m_valid};
        2'd2: begin
          mask = (aw == 32) ? 32'hFFFF_FFFF : ((32'h1 << aw) - 1);
          r = m_caddr & mask;
        end
        default: begin
          mx = (1 << cw) - 1;
          c  = (m_cnt > mx) ? mx : m_cnt;
          r  = (c << 16) | (32'(m_cwrite) << 4) | 32'(m_csize);
        end
      endcase
    end
    return r;
  endfunction

  always @(negedge HCLK) begin
    if (chk_en) begin
      check("prdata_w32",  PRDATA,   exp_rd(32, 8));
      check("prdata_w16",  prdata2,  exp_rd(16, 2));
      check("irq_w32",     32'(IRQ), 32'(m_irq));
      check("irq_w16",     32'(irq2), 32'(m_irq));
      check("pready",      {30'd0, PREADY, pready2}, 32'h3);
      check("pslverr",     {30'd0, PSLVERR, pslverr2}, 32'h0);
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1;
    tick();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [31:0] d1,
                          output logic [31:0] d2);
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
    tick();
    PENABLE = 1;
    #2;
    d1 = PRDATA; d2 = prdata2;
    tick();
    PSEL = 0; PENABLE = 0;
  endtask

  // One accepted address phase, then the slave stalls its data phase
  task automatic ahb_addr(input logic [31:0] a, input logic w, input logic [2:0] s);
    HSELS = 1; HTRANSS = 2'b10; HADDRS = a; HWRITES = w; HSIZES = s; HREADYS = 1;
    tick();
    HTRANSS = 2'b00; HREADYS = 0;
  endtask

  task automatic tout_pulse();
    TIMEOUT = 1;
    tick();
    TIMEOUT = 0;
    tick();
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] r1, r2;

  initial begin
    HRESETn = 1; HSELS = 0; HADDRS = 0; HTRANSS = 0; HWRITES = 0; HSIZES = 0;
    HREADYS = 1; TIMEOUT = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0;
    PWDATA = 0;
    #1 HRESETn = 0;
    chk_en = 1;
    PSEL = 1;
    for (int a = 0; a < 4; a++) begin
      PADDR = 2'(a); #1;
      check("reset_read", PRDATA, 32'h0);
    end
    PSEL = 0;
    check("reset_irq", 32'(IRQ), 32'h0);
    repeat (2) tick();
    HRESETn = 1;
    tick();

    // Basic capture
    apb_write(2'd0, 32'h1);
    ahb_addr(32'h4000_0010, 1'b1, 3'd2);
    TIMEOUT = 1;
    tick();
    check("basic_irq_edge1", 32'(IRQ), 32'h0);
    tick();
    check("basic_irq_edge2", 32'(IRQ), 32'h1);
    TIMEOUT = 0; HREADYS = 1;
    apb_read(2'd1, r1, r2); check("basic_status", r1, 32'h1);
    apb_read(2'd2, r1, r2); check("basic_addr", r1, 32'h4000_0010);
    check("basic_addr_w16", r2, 32'h0000_0010);
    apb_read(2'd3, r1, r2); check("basic_info", r1, 32'h0001_0012);

    // Overflow
    ahb_addr(32'h2000_0000, 1'b0, 3'd2);
    tout_pulse();
    HREADYS = 1;
    apb_read(2'd1, r1, r2); check("ovf_status", r1, 32'h3);
    apb_read(2'd2, r1, r2); check("ovf_addr", r1, 32'h4000_0010);
    apb_read(2'd3, r1, r2); check("ovf_info", r1, 32'h0002_0012);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = 2'd1; PWDATA = 32'h1;
    tick();
    PENABLE = 1;
    tick();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    check("clr_irq_edge_m", 32'(IRQ), 32'h1);
    tick();
    check("clr_irq_edge_m1", 32'(IRQ), 32'h0);
    apb_read(2'd1, r1, r2); check("clr_status", r1, 32'h0);

    // Saturation (narrow instance) and INFO-write clear
    repeat (5) tout_pulse();
    apb_read(2'd3, r1, r2);
    check("sat_info_w32", r1, 32'h0007_0002);
    check("sat_info_w16", r2, 32'h0003_0002);
    apb_write(2'd3, 32'hDEAD_BEEF);
    apb_read(2'd3, r1, r2);
    check("cnt_clr_w32", r1, 32'h0000_0002);
    check("cnt_clr_w16", r2, 32'h0000_0002);

    // STATUS clear together with an event
    ahb_addr(32'h1234_5678, 1'b1, 3'd1);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = 2'd1; PWDATA = 32'h1;
    tick();
    PENABLE = 1; TIMEOUT = 1;
    tick();
    PSEL = 0; PENABLE = 0; PWRITE = 0; TIMEOUT = 0; HREADYS = 1;
    apb_read(2'd1, r1, r2); check("simclr_status", r1, 32'h1);
    apb_read(2'd2, r1, r2); check("simclr_addr", r1, 32'h1234_5678);
    check("simclr_addr_w16", r2, 32'h0000_5678);
    apb_read(2'd3, r1, r2); check("simclr_info", r1, 32'h0001_0011);

    // INFO write together with an event
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = 2'd3; PWDATA = 32'h0;
    tick();
    PENABLE = 1; TIMEOUT = 1;
    tick();
    PSEL = 0; PENABLE = 0; PWRITE = 0; TIMEOUT = 0;
    apb_read(2'd3, r1, r2); check("simcnt_info", r1, 32'h0001_0011);
    apb_read(2'd1, r1, r2); check("simcnt_status", r1, 32'h3);

    // Level held high is one event; IRQEN=0 masks the interrupt
    apb_write(2'd1, 32'h1);
    apb_write(2'd3, 32'h0);
    apb_write(2'd0, 32'h0);
    TIMEOUT = 1;
    repeat (50) begin
      tick();
      check("level_irq_masked", 32'(IRQ), 32'h0);
    end
    apb_read(2'd3, r1, r2); check("level_info", r1, 32'h0001_0011);
    apb_read(2'd1, r1, r2); check("level_status", r1, 32'h5);

    // Reset while TIMEOUT is high and a record is held
    apb_write(2'd0, 32'h1);
    tick();
    HRESETn = 0;
    PSEL = 1; PWRITE = 0;
    for (int a = 0; a < 4; a++) begin
      PADDR = 2'(a); #1;
      check("rst_mid_read", PRDATA, (a == 1) ? 32'h4 : 32'h0);
    end
    check("rst_mid_irq", 32'(IRQ), 32'h0);
    PSEL = 0;
    tick();
    tick();
    HRESETn = 1;
    tick();
    apb_read(2'd3, r1, r2); check("rst_rel_info", r1, 32'h0001_0000);
    apb_read(2'd1, r1, r2); check("rst_rel_status", r1, 32'h5);
    apb_read(2'd2, r1, r2); check("rst_rel_addr", r1, 32'h0);
    TIMEOUT = 0;

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      HSELS   = 1'($urandom);
      HTRANSS = 2'($urandom);
      HADDRS  = $urandom;
      HWRITES = 1'($urandom);
      HSIZES  = 3'($urandom);
      HREADYS = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) TIMEOUT = ~TIMEOUT;
      PSEL    = 1'($urandom);
      PENABLE = 1'($urandom);
      PWRITE  = ($urandom_range(0, 3) == 0);
      PADDR   = 2'($urandom);
      PWDATA  = $urandom;
      HRESETn = ($urandom_range(0, 299) != 0);
      tick();
    end
    HRESETn = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
